control_filtro_pb: RTL

CONTROL_FILTRO_PB -- requirements
Module: control_filtro_pb

---
 rtl/control_filtro_pb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/control_filtro_pb.sv
// Sequencer for a second-order Direct-Form-II IIR datapath: drives the
// register enables and operand mux selects for one output sample per start.
module control_filtro_pb #(
  parameter int WAIT_ARIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clr_ovr,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4,
  output logic       en5,
  output logic       en6,
  output logic       en7,
  output logic [2:0] selmuxS,
  output logic [2:0] selmuxZ,
  output logic [1:0] selmuxC,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, OP1, OP2, OP3, OP4, OP5, SHIFT} state_t;

  localparam logic [2:0] WAIT_W = 3'(WAIT_ARIT);

  state_t     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [7:1] en_q, en_d;
  logic [2:0] sel_s_q, sel_s_d;
  logic [2:0] sel_z_q, sel_z_d;
  logic [1:0] sel_c_q, sel_c_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       overrun_q, overrun_d;
  logic       write;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (start) state_d = OP1;
      end
      SHIFT: begin
        state_d = IDLE;
        phase_d = '0;
      end
      default: begin
        // Phase WAIT_ARIT is the write cycle; phase restarts on every OP entry.
        if (phase_q == WAIT_W) begin
          phase_d = '0;
          unique case (state_q)
            OP1:     state_d = OP2;
            OP2:     state_d = OP3;
            OP3:     state_d = OP4;
            OP4:     state_d = OP5;
            default: state_d = SHIFT;
          endcase
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they are flops aligned with it.
  always_comb begin
    write   = (phase_d == WAIT_W);
    en_d    = '0;
    sel_s_d = '0;
    sel_z_d = '0;
    sel_c_d = '0;
    done_d  = 1'b0;
    busy_d  = (state_d != IDLE);
    unique case (state_d)
      OP1: begin
        sel_s_d = 3'd2; sel_c_d = 2'd0; sel_z_d = 3'd4; en_d[5] = write;
      end
      OP2: begin
        sel_s_d = 3'd3; sel_c_d = 2'd1; sel_z_d = 3'd1; en_d[2] = write;
      end
      OP3: begin
        sel_s_d = 3'd1; sel_c_d = 2'd2; sel_z_d = 3'd0; en_d[6] = write;
      end
      OP4: begin
        sel_s_d = 3'd2; sel_c_d = 2'd3; sel_z_d = 3'd2; en_d[7] = write;
      end
      OP5: begin
        sel_s_d = 3'd3; sel_c_d = 2'd2; sel_z_d = 3'd3; en_d[1] = write;
      end
      SHIFT: begin
        en_d[3] = 1'b1;
        en_d[4] = 1'b1;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // A start that arrives while busy is dropped; setting wins over clearing.
  always_comb begin
    overrun_d = overrun_q;
    if (start && state_q != IDLE) overrun_d = 1'b1;
    else if (clr_ovr)             overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      en_q      <= '0;
      sel_s_q   <= '0;
      sel_z_q   <= '0;
      sel_c_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      en_q      <= en_d;
      sel_s_q   <= sel_s_d;
      sel_z_q   <= sel_z_d;
      sel_c_q   <= sel_c_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign en1     = en_q[1];
  assign en2     = en_q[2];
  assign en3     = en_q[3];
  assign en4     = en_q[4];
  assign en5     = en_q[5];
  assign en6     = en_q[6];
  assign en7     = en_q[7];
  assign selmuxS = sel_s_q;
  assign selmuxZ = sel_z_q;
  assign selmuxC = sel_c_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
